// File: rtl/shifter_unit_if.sv
// Request/response bundle for the iterative barrel shifter.
// The master issues shift requests and consumes results; the slave is the shifter.
interface shifter_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] shiftee;
  logic [2:0]  shift_type;
  logic [7:0]  shift_amount;
  logic        carry_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        carry_out;

  modport master (
    output in_valid, shiftee, shift_type, shift_amount, carry_in, out_ready,
    input  in_ready, out_valid, result, carry_out
  );

  modport slave (
    input  in_valid, shiftee, shift_type, shift_amount, carry_in, out_ready,
    output in_ready, out_valid, result, carry_out
  );
endinterface

// File: rtl/shifter_unit.sv
// Iterative ARM barrel shifter: shifts the latched operand up to STEP bits
// per cycle and returns shifter_operand plus shifter carry-out.
//
// state | meaning
// IDLE  | ready for a request, nothing in flight
// SHIFT | shifting the work register, remaining counts down to zero
// DONE  | result/carry held on the output until accepted
module shifter_unit #(
  parameter int STEP = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  shifter_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [2:0] K_LSL = 3'd0;
  localparam logic [2:0] K_LSR = 3'd1;
  localparam logic [2:0] K_ASR = 3'd2;
  localparam logic [2:0] K_ROR = 3'd3;
  localparam logic [2:0] K_RRX = 3'd4;
  localparam logic [5:0] STEP_W = 6'(STEP);

  state_t      state, state_nxt;
  logic [31:0] work, work_nxt;
  logic        c_reg, c_nxt;
  logic [5:0]  remaining, remaining_nxt;
  logic [2:0]  kind, kind_nxt;

  logic [2:0]  acc_kind;
  logic [5:0]  acc_n;
  logic        acc_c;

  logic [5:0]  step_k;
  logic [4:0]  lsl_idx;
  logic [4:0]  low_idx;
  logic [31:0] step_work;
  logic        step_c;

  logic        in_ready_i;
  logic        out_valid_i;

  // Decode a new request into its operation kind, effective count and initial carry
  always_comb begin
    acc_kind = (bus.shift_type > K_RRX) ? K_LSL : bus.shift_type;
    acc_n    = '0;
    acc_c    = bus.carry_in;
    case (acc_kind)
      K_LSL, K_LSR: acc_n = (bus.shift_amount > 8'd33) ? 6'd33 : bus.shift_amount[5:0];
      K_ASR:        acc_n = (bus.shift_amount > 8'd32) ? 6'd32 : bus.shift_amount[5:0];
      K_ROR: begin
        // A nonzero multiple of 32 leaves the value intact but still updates carry
        if (bus.shift_amount[4:0] == 5'd0) begin
          acc_n = '0;
          if (bus.shift_amount != 8'd0) acc_c = bus.shiftee[31];
        end else begin
          acc_n = {1'b0, bus.shift_amount[4:0]};
        end
      end
      K_RRX:   acc_n = 6'd1;
      default: acc_n = '0;
    endcase
  end

  // One shift step of k = min(STEP, remaining) positions; carry is the last bit shifted out
  always_comb begin
    step_k    = (remaining < STEP_W) ? remaining : STEP_W;
    lsl_idx   = 5'(6'd32 - step_k);
    low_idx   = 5'(step_k - 6'd1);
    step_work = work;
    step_c    = c_reg;
    case (kind)
      K_LSL: begin
        step_work = work << step_k;
        step_c    = work[lsl_idx];
      end
      K_LSR: begin
        step_work = work >> step_k;
        step_c    = work[low_idx];
      end
      K_ASR: begin
        step_work = $signed(work) >>> step_k;
        step_c    = work[low_idx];
      end
      K_ROR: begin
        step_work = (work >> step_k) | (work << (6'd32 - step_k));
        step_c    = work[low_idx];
      end
      K_RRX: begin
        step_work = {c_reg, work[31:1]};
        step_c    = work[0];
      end
      default: begin
        step_work = work;
        step_c    = c_reg;
      end
    endcase
  end

  // Next-state, datapath updates and handshake outputs
  always_comb begin
    state_nxt     = state;
    work_nxt      = work;
    c_nxt         = c_reg;
    remaining_nxt = remaining;
    kind_nxt      = kind;
    in_ready_i    = 1'b0;
    out_valid_i   = 1'b0;
    case (state)
      IDLE: begin
        in_ready_i = 1'b1;
        if (bus.in_valid) begin
          work_nxt      = bus.shiftee;
          c_nxt         = acc_c;
          remaining_nxt = acc_n;
          kind_nxt      = acc_kind;
          state_nxt     = (acc_n != 6'd0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        work_nxt      = step_work;
        c_nxt         = step_c;
        remaining_nxt = remaining - step_k;
        if (remaining <= STEP_W) state_nxt = DONE;
      end
      DONE: begin
        out_valid_i = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath registers; cleared by reset so an abandoned request leaves nothing behind
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work      <= '0;
      c_reg     <= 1'b0;
      remaining <= '0;
      kind      <= K_LSL;
    end else begin
      work      <= work_nxt;
      c_reg     <= c_nxt;
      remaining <= remaining_nxt;
      kind      <= kind_nxt;
    end
  end

  assign bus.in_ready  = in_ready_i;
  assign bus.out_valid = out_valid_i;
  assign bus.result    = work;
  assign bus.carry_out = c_reg;

endmodule
